// File: rtl/sync_fifo_ctrl_if.sv
// Producer/consumer bundle for sync_fifo_ctrl: push/pop requests, pop data and
// the status/error flags. The master side drives requests and the FIFO is the slave.
interface sync_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 7
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] din;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] dout;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr_en, din, rd_en,
        input  dout, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, din, rd_en,
        output dout, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO front end: pointer/occupancy management, registered status
// flags and error pulses around a synchronous simple dual-port RAM.
module simple_dual_port_ram_sync #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clka,
    input  logic                  wena,
    input  logic [ADDR_WIDTH-1:0] waddra,
    input  logic [DATA_WIDTH-1:0] dina,
    input  logic                  clkb,
    input  logic                  rst_n,
    input  logic                  renb,
    input  logic [ADDR_WIDTH-1:0] raddrb,
    output logic [DATA_WIDTH-1:0] doutb
);
    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

    // Write port; the array is deliberately left unreset.
    always_ff @(posedge clka) begin
        if (wena) begin
            mem_q[waddra] <= dina;
        end
    end

    // Registered read port; holds the last word while renb is low.
    always_ff @(posedge clkb or negedge rst_n) begin
        if (!rst_n) begin
            doutb <= {DATA_WIDTH{1'b0}};
        end else if (renb) begin
            doutb <= mem_q[raddrb];
        end
    end
endmodule

module sync_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 7,
    parameter int AF_LEVEL   = 2**ADDR_WIDTH - 4,
    parameter int AE_LEVEL   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    sync_fifo_ctrl_if.slave  bus
);
    localparam logic [ADDR_WIDTH:0] ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] AF_LVL = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_LVL = (ADDR_WIDTH+1)'(AE_LEVEL);

    logic [ADDR_WIDTH:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH:0] rptr_q, rptr_d;
    logic [ADDR_WIDTH:0] count_q, count_d;
    logic                full_q, full_d;
    logic                empty_q, empty_d;
    logic                af_q, af_d;
    logic                ae_q, ae_d;
    logic                rd_valid_q;
    logic                overflow_q;
    logic                underflow_q;
    logic                wr_acc_s;
    logic                rd_acc_s;

    // Acceptance looks only at registered flags, so no request reaches a flag combinationally.
    always_comb begin
        wr_acc_s = bus.wr_en & ~full_q;
        rd_acc_s = bus.rd_en & ~empty_q;
        if (wr_acc_s) begin
            wptr_d = wptr_q + ONE;
        end else begin
            wptr_d = wptr_q;
        end
        if (rd_acc_s) begin
            rptr_d = rptr_q + ONE;
        end else begin
            rptr_d = rptr_q;
        end
        count_d = wptr_d - rptr_d;
        full_d  = (wptr_d[ADDR_WIDTH-1:0] == rptr_d[ADDR_WIDTH-1:0]) &&
                  (wptr_d[ADDR_WIDTH] != rptr_d[ADDR_WIDTH]);
        empty_d = (wptr_d == rptr_d);
        af_d    = (count_d >= AF_LVL);
        ae_d    = (count_d <= AE_LVL);
    end

    // Pointer, occupancy, flag and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= {(ADDR_WIDTH+1){1'b0}};
            rptr_q      <= {(ADDR_WIDTH+1){1'b0}};
            count_q     <= {(ADDR_WIDTH+1){1'b0}};
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            af_q        <= 1'b0;
            ae_q        <= 1'b1;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            af_q        <= af_d;
            ae_q        <= ae_d;
            rd_valid_q  <= rd_acc_s;
            overflow_q  <= bus.wr_en & full_q;
            underflow_q <= bus.rd_en & empty_q;
        end
    end

    simple_dual_port_ram_sync #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clka   (clk),
        .wena   (wr_acc_s),
        .waddra (wptr_q[ADDR_WIDTH-1:0]),
        .dina   (bus.din),
        .clkb   (clk),
        .rst_n  (rst_n),
        .renb   (rd_acc_s),
        .raddrb (rptr_q[ADDR_WIDTH-1:0]),
        .doutb  (bus.dout)
    );

    assign bus.rd_valid     = rd_valid_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl at depth 8: a scoreboard queue holds the
// words expected on the pop side and a monitor compares them as rd_valid fires.
module tb_sync_fifo_ctrl;
    localparam int DW = 8;
    localparam int AW = 3;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   mcnt;
    logic [DW-1:0] exp_q[$];

    sync_fifo_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) fifo_if ();

    sync_fifo_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .AF_LEVEL   (6),
        .AE_LEVEL   (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (fifo_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Pop-side monitor: every rd_valid must match the oldest outstanding word.
    always @(negedge clk) begin
        if (fifo_if.rd_valid === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL dout: unexpected rd_valid with dout %0h", fifo_if.dout);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (fifo_if.dout !== e) begin
                    bad++;
                    $display("FAIL dout: got %0h expected %0h at %0t", fifo_if.dout, e, $time);
                end
            end
        end
    end

    // One clock: drive at negedge, predict with a count model, check after the edge.
    task automatic step(input logic wr, input logic [DW-1:0] d, input logic rd);
        logic wa, ra, ov, un;
        @(negedge clk);
        fifo_if.wr_en = wr;
        fifo_if.din   = d;
        fifo_if.rd_en = rd;
        wa = wr && (mcnt < 8);
        ra = rd && (mcnt > 0);
        ov = wr && (mcnt == 8);
        un = rd && (mcnt == 0);
        if (wa) exp_q.push_back(d);
        @(posedge clk);
        #1;
        mcnt = mcnt + (wa ? 1 : 0) - (ra ? 1 : 0);
        chk("count",        32'(fifo_if.count),        32'(mcnt));
        chk("full",         32'(fifo_if.full),         32'(mcnt == 8));
        chk("empty",        32'(fifo_if.empty),        32'(mcnt == 0));
        chk("almost_full",  32'(fifo_if.almost_full),  32'(mcnt >= 6));
        chk("almost_empty", 32'(fifo_if.almost_empty), 32'(mcnt <= 2));
        chk("overflow",     32'(fifo_if.overflow),     32'(ov));
        chk("underflow",    32'(fifo_if.underflow),    32'(un));
        chk("rd_valid",     32'(fifo_if.rd_valid),     32'(ra));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_count"},     32'(fifo_if.count),        32'd0);
        chk({tag, "_full"},      32'(fifo_if.full),         32'd0);
        chk({tag, "_empty"},     32'(fifo_if.empty),        32'd1);
        chk({tag, "_af"},        32'(fifo_if.almost_full),  32'd0);
        chk({tag, "_ae"},        32'(fifo_if.almost_empty), 32'd1);
        chk({tag, "_rd_valid"},  32'(fifo_if.rd_valid),     32'd0);
        chk({tag, "_overflow"},  32'(fifo_if.overflow),     32'd0);
        chk({tag, "_underflow"}, 32'(fifo_if.underflow),    32'd0);
        chk({tag, "_dout"},      32'(fifo_if.dout),         32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        mcnt  = 0;
        fifo_if.wr_en = 1'b0;
        fifo_if.din   = 8'h00;
        fifo_if.rd_en = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step(1'b0, 8'h00, 1'b0);
        chk_reset("idle");

        // Fill to full, then one rejected push.
        for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0);
        step(1'b1, 8'h09, 1'b0);
        step(1'b0, 8'h00, 1'b0);

        // Drain back-to-back, then one rejected pop.
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        // Interleaved traffic across pointer wraps.
        for (int i = 0; i < 20; i++) step(1'b1, 8'(8'h10 + i), (i >= 3));
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        // Simultaneous push/pop when full, when empty, and mid-occupancy.
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
        step(1'b1, 8'h38, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h40, 1'b1);
        for (int i = 1; i < 4; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
        step(1'b1, 8'h44, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        // Thresholds, then asynchronous reset in the middle of a burst at count 5.
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h50 + i), 1'b0);
        step(1'b0, 8'h00, 1'b1);
        @(negedge clk);
        fifo_if.wr_en = 1'b1;
        fifo_if.din   = 8'h56;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("async_rst");
        exp_q.delete();
        mcnt = 0;
        @(posedge clk);
        #1;
        chk_reset("rst_hold");
        @(negedge clk);
        fifo_if.wr_en = 1'b0;
        rst_n = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        chk_reset("post_rst");

        // Every push must have been consumed.
        chk("scoreboard_left", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
- Single-clock synchronous FIFO: the push/pop front end for the team's dual-port RAM storage.
- Manages write/read pointers, occupancy, status flags and error pulses.
- Storage is one simple_dual_port_ram_sync instance with clka = clkb = clk, so read data arrives one cycle after an accepted pop.
- Sits between a producer and a consumer in the same clock domain.

Parameters:
- DATA_WIDTH, 8, word width.
- ADDR_WIDTH, 7, RAM address width; DEPTH = 2**ADDR_WIDTH (128).
- AF_LEVEL, 2**ADDR_WIDTH-4, almost_full threshold: count >= AF_LEVEL.
- AE_LEVEL, 4, almost_empty threshold: count <= AE_LEVEL.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  push request.
- din  input  DATA_WIDTH  push data.
- rd_en  input  1  pop request.
- dout  output  DATA_WIDTH  pop data; valid when rd_valid = 1.
- rd_valid  output  1  registered pulse; dout holds the word from the pop accepted the previous cycle.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_LEVEL.
- almost_empty  output  1  count <= AE_LEVEL.
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  output  1  registered one-cycle pulse: wr_en while full.
- underflow  output  1  registered one-cycle pulse: rd_en while empty.

Behaviour:
- Reset (async assert, sync release):
  - wptr = rptr = count = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - rd_valid = overflow = underflow = 0, dout = 0.
- Pointers:
  - wptr and rptr are ADDR_WIDTH+1 bits.
  - RAM address = low ADDR_WIDTH bits; the MSB is the wrap flag.
  - Pointers wrap naturally modulo 2*DEPTH.
  - full = (addresses equal) and (MSBs differ); empty = (pointers equal).
  - count = wptr - rptr, modulo 2**(ADDR_WIDTH+1).
- Acceptance, evaluated on registered state at the clock edge:
  - wr_acc = wr_en & ~full; rd_acc = rd_en & ~empty.
- Push: wr_acc drives wena = 1, waddra = wptr[ADDR_WIDTH-1:0], dina = din; wptr increments.
- Pop:
  - rd_acc drives renb = 1, raddrb = rptr[ADDR_WIDTH-1:0]; rptr increments.
  - Next cycle: rd_valid = 1 and dout = that word.
  - dout holds its last value when rd_valid = 0.
- Simultaneous push and pop:
  - Both accepted: count unchanged.
  - When full: only the pop is accepted, full drops next cycle, overflow pulses.
  - When empty: only the push is accepted, empty drops next cycle, underflow pulses; no read-before-write bypass.
- Latency:
  - A word pushed at edge N can be popped from edge N+1 (empty low after N).
  - Its data appears at edge N+2 with rd_valid = 1.
- Rejected requests change no state other than the overflow/underflow pulse.
- Flags are derived only from registered pointers, with no combinational path from wr_en/rd_en.
- Reset mid-operation: all state returns to reset values immediately; FIFO contents are discarded (RAM array not cleared; data is unreachable).
- Ordering: strict FIFO ordering through all wrap-arounds.

Test Plan:
- Reset, then idle 3 cycles -> empty = 1, full = 0, count = 0, rd_valid = 0, dout = 0.
- ADDR_WIDTH = 3: push 0x01..0x08 on 8 consecutive cycles -> full = 1 and count = 8 after the 8th edge; a 9th push of 0x09 -> overflow = 1 for one cycle, count stays 8.
- Pop 8 times back-to-back -> rd_valid high for 8 cycles starting one cycle after the first pop; dout = 0x01..0x08 in order; empty = 1 after the last pop; a further pop -> underflow pulse, rd_valid = 0.
- Interleave pushes and pops for 20 words (0x10..0x23) so pointers wrap twice -> output sequence identical, count never exceeds 8, no error pulses.
- Simultaneous wr_en and rd_en:
  - When full: pop of the oldest word accepted, push rejected with overflow, count 8 -> 7.
  - When empty: push accepted, underflow, count 0 -> 1.
  - At count 4: count stays 4.
- Thresholds AF_LEVEL = 6, AE_LEVEL = 2 -> almost_empty deasserts at count 3, almost_full asserts at count 6; assert rst_n low at count 5 mid-burst -> all outputs return to reset values asynchronously.
